spi_slave_ctrl: RTL and testbench

SPI responder (slave) controller: the far end of the SPI master control block, in the same single `clk_i` system domain. It oversamples the external SPI clock, chip-select and MOSI through synchronisers, and shifts bytes in on MOSI and out on MISO in SPI mode 0 (CPOL=0, CPHA=0), MSB first. It presents each received byte to the system with a one-cycle valid pulse and accepts transmit bytes through a one-entry valid/ready buffer.

---
 rtl/spi_slave_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_spi_slave_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_ctrl
// Purpose  : SPI responder, mode 0 (CPOL=0, CPHA=0), MSB first. The SPI pins
//            are oversampled in the clk_i domain through synchronisers. Each
//            received word is presented with a one-cycle valid pulse. Transmit
//            words come in through a one-entry valid/ready buffer.
// Ports    : clk_i, rstn_i        system clock, async active-low reset
//            spi_clk_i/cs_n/mosi  SPI pins from the master (asynchronous)
//            spi_miso_o           serial data to the master
//            tx_data/valid/ready  transmit buffer handshake
//            rx_data_o/rx_valid_o last received word and its update pulse
//            tx_underrun_o        word started with the transmit buffer empty
//            busy_o               synchronised chip select is active
// Revision : 1.0 - initial release
// ============================================================================
module spi_slave_ctrl #(
  parameter int unsigned               DATA_WIDTH   = 8,
  parameter int unsigned               SYNC_STAGES  = 2,
  parameter logic [DATA_WIDTH-1:0]     IDLE_PATTERN = 8'hFF
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  spi_clk_i,
  input  logic                  spi_cs_n_i,
  input  logic                  spi_mosi_i,
  output logic                  spi_miso_o,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_valid_o,
  output logic                  tx_underrun_o,
  output logic                  busy_o
);

  localparam int unsigned            c_CNT_W    = $clog2(DATA_WIDTH + 1);
  localparam logic [c_CNT_W-1:0]     c_CNT_FULL = c_CNT_W'(DATA_WIDTH);
  localparam int unsigned            c_MSB      = DATA_WIDTH - 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Synchronisers plus one edge-detect register per pin
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sck_d;
  logic                   r_cs_d;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_sck_sync  <= '0;
      r_cs_sync   <= '1;   // chip select idles inactive (high)
      r_mosi_sync <= '0;
      r_sck_d     <= 1'b0;
      r_cs_d      <= 1'b1;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], spi_clk_i};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n_i};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
      r_sck_d     <= r_sck_sync[SYNC_STAGES-1];
      r_cs_d      <= r_cs_sync[SYNC_STAGES-1];
    end
  end

  logic w_sck_s, w_cs_s, w_mosi_s;
  logic w_sck_rise, w_sck_fall, w_cs_fall, w_cs_rise;

  assign w_sck_s    = r_sck_sync[SYNC_STAGES-1];
  assign w_cs_s     = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi_s   = r_mosi_sync[SYNC_STAGES-1];
  assign w_sck_rise =  w_sck_s & ~r_sck_d;
  assign w_sck_fall = ~w_sck_s &  r_sck_d;
  assign w_cs_fall  = ~w_cs_s  &  r_cs_d;
  assign w_cs_rise  =  w_cs_s  & ~r_cs_d;

  // --------------------------------------------------------------------------
  // State machine
  // --------------------------------------------------------------------------
  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_do_load;
  logic                 w_word_done;
  logic                 w_abort;
  logic                 w_miso;

  logic [c_CNT_W-1:0]    r_cnt;
  logic [DATA_WIDTH-1:0] r_tx_shift;
  logic [DATA_WIDTH-1:0] r_rx_shift;
  logic [DATA_WIDTH-1:0] r_buf;
  logic                  r_buf_full;
  logic [DATA_WIDTH-1:0] r_rx_data;
  logic                  r_rx_valid;
  logic                  r_tx_underrun;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_do_load   = 1'b0;
    w_word_done = 1'b0;
    w_abort     = 1'b0;
    w_miso      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_cs_fall) begin
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        w_do_load   = 1'b1;
        w_state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        w_miso = r_tx_shift[c_MSB];
        // Counter reached full on the previous rise: hand the word over
        // and reload for a possible back-to-back word.
        if (r_cnt == c_CNT_FULL) begin
          w_word_done = 1'b1;
          w_state_nxt = S_LOAD;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    // Chip-select release wins over everything and drops a partial word.
    if (w_cs_rise) begin
      w_abort     = 1'b1;
      w_do_load   = 1'b0;
      w_word_done = 1'b0;
      w_state_nxt = S_IDLE;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath: shift registers, bit counter, transmit buffer, output pulses
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_cnt         <= '0;
      r_tx_shift    <= '0;
      r_rx_shift    <= '0;
      r_buf         <= '0;
      r_buf_full    <= 1'b0;
      r_rx_data     <= '0;
      r_rx_valid    <= 1'b0;
      r_tx_underrun <= 1'b0;
    end else begin
      r_rx_valid    <= 1'b0;
      r_tx_underrun <= 1'b0;

      // Handshake only when empty; LOAD only clears when full, so the two
      // never collide. A handshake during LOAD lands for the next word.
      if (tx_valid_i && !r_buf_full) begin
        r_buf      <= tx_data_i;
        r_buf_full <= 1'b1;
      end

      if (w_abort) begin
        r_cnt      <= '0;
        r_tx_shift <= '0;
        r_rx_shift <= '0;
      end else if (w_do_load) begin
        if (r_buf_full) begin
          r_tx_shift <= r_buf;
          r_buf_full <= 1'b0;
        end else begin
          r_tx_shift    <= IDLE_PATTERN;
          r_tx_underrun <= 1'b1;
        end
      end else if (w_word_done) begin
        r_rx_data  <= r_rx_shift;
        r_rx_valid <= 1'b1;
        r_cnt      <= '0;
      end else if (r_state == S_SHIFT) begin
        if (w_sck_rise) begin
          r_rx_shift <= {r_rx_shift[c_MSB-1:0], w_mosi_s};
          r_cnt      <= r_cnt + c_CNT_W'(1);
        end
        // A fall with the counter at zero is the trailing edge of the
        // previous word arriving after the reload; shifting then would
        // throw away the MSB of the freshly loaded word.
        if (w_sck_fall && (r_cnt != '0) && (r_cnt != c_CNT_FULL)) begin
          r_tx_shift <= {r_tx_shift[c_MSB-1:0], 1'b0};
        end
      end
    end
  end

  assign spi_miso_o    = w_miso;
  assign tx_ready_o    = ~r_buf_full;
  assign rx_data_o     = r_rx_data;
  assign rx_valid_o    = r_rx_valid;
  assign tx_underrun_o = r_tx_underrun;
  assign busy_o        = ~w_cs_s;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_slave_ctrl
// Purpose  : Self-checking bench for spi_slave_ctrl. A bit-banged SPI master
//            drives the pins; a transaction-level model tracks the transmit
//            buffer, the word expected on MISO and the underrun count.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_slave_ctrl;

  localparam int c_DW   = 8;
  localparam int c_HALF = 8;   // SCK half period in clk cycles

  logic            clk = 1'b0;
  logic            rstn;
  logic            spi_clk, spi_cs_n, spi_mosi, spi_miso;
  logic [c_DW-1:0] tx_data;
  logic            tx_valid, tx_ready;
  logic [c_DW-1:0] rx_data;
  logic            rx_valid, tx_underrun, busy;

  spi_slave_ctrl #(
    .DATA_WIDTH  (c_DW),
    .SYNC_STAGES (2),
    .IDLE_PATTERN(8'hFF)
  ) u_dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .spi_clk_i    (spi_clk),
    .spi_cs_n_i   (spi_cs_n),
    .spi_mosi_i   (spi_mosi),
    .spi_miso_o   (spi_miso),
    .tx_data_i    (tx_data),
    .tx_valid_i   (tx_valid),
    .tx_ready_o   (tx_ready),
    .rx_data_o    (rx_data),
    .rx_valid_o   (rx_valid),
    .tx_underrun_o(tx_underrun),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Observed pulses
  logic [c_DW-1:0] rx_q[$];
  int              n_underrun = 0;

  always @(negedge clk) begin
    if (rx_valid)    rx_q.push_back(rx_data);
    if (tx_underrun) n_underrun++;
  end

  // Reference model state
  logic            m_full;
  logic [c_DW-1:0] m_buf;
  logic [c_DW-1:0] m_rx_last;
  int              m_underrun;

  // Per-transaction stimulus
  logic [c_DW-1:0] xf_mosi   [4];
  logic [c_DW-1:0] xf_refill [4];
  bit              xf_refill_en [4];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // A word starts: it takes the buffered word if there is one, else idles.
  task automatic model_word_start(output logic [c_DW-1:0] exp_tx);
    if (m_full) begin
      exp_tx = m_buf;
      m_full = 1'b0;
    end else begin
      exp_tx = 8'hFF;
      m_underrun++;
    end
  endtask

  task automatic buf_write(input logic [c_DW-1:0] d);
    @(negedge clk);
    check_eq("tx_ready_before_write", tx_ready, !m_full);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    if (!m_full) begin
      m_buf  = d;
      m_full = 1'b1;
    end
  endtask

  task automatic xf_clear();
    for (int i = 0; i < 4; i++) begin
      xf_mosi[i]      = '0;
      xf_refill[i]    = '0;
      xf_refill_en[i] = 1'b0;
    end
  endtask

  // One chip-select frame of nwords words; abort_rises > 0 raises CS after
  // that many SCK rises (never on a word boundary).
  task automatic xfer(input int nwords, input int abort_rises);
    logic [c_DW-1:0] exp_tx, got;
    int  rises, done_words;
    bit  aborted;
    rx_q.delete();
    n_underrun = 0;
    m_underrun = 0;
    rises      = 0;
    done_words = 0;
    aborted    = 1'b0;
    got        = '0;
    spi_cs_n   = 1'b0;
    model_word_start(exp_tx);
    wait_clks(10);
    check_eq("busy_active", busy, 1);
    for (int w = 0; w < nwords && !aborted; w++) begin
      for (int b = c_DW-1; b >= 0 && !aborted; b--) begin
        spi_mosi = xf_mosi[w][b];
        if (xf_refill_en[w] && b == c_DW-3) begin
          buf_write(xf_refill[w]);
          wait_clks(c_HALF-2);
        end else begin
          wait_clks(c_HALF);
        end
        got[b]  = spi_miso;
        spi_clk = 1'b1;
        rises++;
        if (b == 0) check_eq("underrun_within_word", n_underrun, m_underrun);
        wait_clks(c_HALF);
        spi_clk = 1'b0;
        if (rises == abort_rises) aborted = 1'b1;
      end
      if (!aborted) begin
        check_eq("miso_word", got, exp_tx);
        m_rx_last = xf_mosi[w];
        done_words++;
        model_word_start(exp_tx);  // reload that follows every full word
      end
    end
    wait_clks(c_HALF);
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    wait_clks(12);
    check_eq("rx_valid_count", rx_q.size(), done_words);
    for (int i = 0; i < done_words && i < rx_q.size(); i++)
      check_eq("rx_data_word", rx_q[i], xf_mosi[i]);
    check_eq("rx_data_held", rx_data, m_rx_last);
    check_eq("underrun_count", n_underrun, m_underrun);
    check_eq("tx_ready_after", tx_ready, !m_full);
    check_eq("busy_idle", busy, 0);
    check_eq("miso_idle", spi_miso, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nw, ab;
    rstn      = 1'b0;
    spi_clk   = 1'b0;
    spi_cs_n  = 1'b1;
    spi_mosi  = 1'b0;
    tx_data   = '0;
    tx_valid  = 1'b0;
    m_full    = 1'b0;
    m_buf     = '0;
    m_rx_last = '0;
    m_underrun = 0;
    xf_clear();
    wait_clks(3);
    check_eq("rst_miso",     spi_miso,    0);
    check_eq("rst_tx_ready", tx_ready,    1);
    check_eq("rst_rx_data",  rx_data,     0);
    check_eq("rst_rx_valid", rx_valid,    0);
    check_eq("rst_underrun", tx_underrun, 0);
    check_eq("rst_busy",     busy,        0);
    rstn = 1'b1;
    wait_clks(5);

    // Single word
    xf_clear();
    xf_mosi[0] = 8'h3C;
    buf_write(8'hA5);
    check_eq("tx_ready_full", tx_ready, 0);
    xfer(1, -1);

    // Back-to-back words with a refill during the first
    xf_clear();
    xf_mosi[0] = 8'hC3; xf_mosi[1] = 8'h5A;
    xf_refill[0] = 8'h02; xf_refill_en[0] = 1'b1;
    buf_write(8'h01);
    xfer(2, -1);

    // Underrun
    xf_clear();
    xf_mosi[0] = 8'h96;
    xfer(1, -1);

    // Abort after 5 rises, then a full word
    xf_clear();
    xf_mosi[0] = 8'hE7;
    buf_write(8'h4B);
    xfer(1, 5);
    xf_clear();
    xf_mosi[0] = 8'h81;
    buf_write(8'h6D);
    xfer(1, -1);

    // Write while full is ignored
    xf_clear();
    xf_mosi[0] = 8'h24;
    buf_write(8'h11);
    buf_write(8'h77);
    xfer(1, -1);

    // Randomised frames
    for (int t = 0; t < 20; t++) begin
      xf_clear();
      nw = $urandom_range(1, 3);
      for (int w = 0; w < nw; w++) begin
        xf_mosi[w]      = c_DW'($urandom);
        xf_refill[w]    = c_DW'($urandom);
        xf_refill_en[w] = ($urandom_range(0, 1) == 1);
      end
      if ($urandom_range(0, 1) == 1) buf_write(c_DW'($urandom));
      ab = -1;
      if ($urandom_range(0, 3) == 0) begin
        ab = $urandom_range(1, nw*c_DW - 1);
        if (ab % c_DW == 0) ab = ab - 1;
      end
      xfer(nw, ab);
      wait_clks($urandom_range(2, 10));
    end

    // Asynchronous reset after 3 SCK rises
    xf_clear();
    buf_write(8'h5A);
    rx_q.delete();
    n_underrun = 0;
    spi_cs_n = 1'b0;
    wait_clks(10);
    for (int b = 0; b < 3; b++) begin
      spi_mosi = 1'($urandom);
      wait_clks(c_HALF);
      spi_clk = 1'b1;
      wait_clks(c_HALF);
      spi_clk = 1'b0;
    end
    wait_clks(3);
    #2;
    rstn = 1'b0;
    #1;
    check_eq("arst_miso",     spi_miso,    0);
    check_eq("arst_tx_ready", tx_ready,    1);
    check_eq("arst_rx_data",  rx_data,     0);
    check_eq("arst_rx_valid", rx_valid,    0);
    check_eq("arst_underrun", tx_underrun, 0);
    check_eq("arst_busy",     busy,        0);
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    wait_clks(5);
    rstn = 1'b1;
    m_full    = 1'b0;
    m_rx_last = '0;
    wait_clks(10);
    check_eq("arst_no_rx_pulse",       rx_q.size(), 0);
    check_eq("arst_no_underrun_pulse", n_underrun,  0);

    // Recovery after reset
    xf_clear();
    xf_mosi[0] = 8'hB4;
    buf_write(8'h39);
    xfer(1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
